// File: rtl/spike_window_counter.sv
// Counts spikes across all lanes over a programmable window of enabled cycles
// and queues each window's {saturated, count} result in a small FIFO.
module spike_window_counter #(
    parameter int LANES      = 8,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [LANES-1:0] spikes_in,
    input  logic [7:0]       win_len,
    input  logic             start,
    input  logic             stop,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             busy,
    output logic             drop
);

    localparam int PC_W   = $clog2(LANES + 1);
    localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [8:0]         win_q, win_d;
    logic [CNT_W:0]     mem_q [FIFO_DEPTH];
    logic [CNT_W:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               drop_q, drop_d;

    logic [SUM_W-1:0]   sum_s;
    logic               clip_s;
    logic [CNT_W-1:0]   acc_sum_s;
    logic               close_s;
    logic               push_s;
    logic [CNT_W:0]     push_data_s;
    logic               pop_s, full_s, push_ok_s;

    // Window FSM: accumulate with saturation and close on the last enabled cycle
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        push_s      = 1'b0;
        sum_s       = SUM_W'(acc_q) + SUM_W'(popcount(spikes_in));
        clip_s      = (sum_s > ACC_MAX);
        acc_sum_s   = clip_s ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
        close_s     = ((cnt_q + 9'd1) == win_q);
        push_data_s = {sat_q | clip_s, acc_sum_s};
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_ACCUM;
                    win_d   = (win_len == 8'd0) ? 9'd256 : {1'b0, win_len};
                    acc_d   = {CNT_W{1'b0}};
                    sat_d   = 1'b0;
                    cnt_d   = 9'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    acc_d   = {CNT_W{1'b0}};
                    sat_d   = 1'b0;
                    cnt_d   = 9'd0;
                end else if (ena) begin
                    if (close_s) begin
                        push_s = 1'b1;
                        acc_d  = {CNT_W{1'b0}};
                        sat_d  = 1'b0;
                        cnt_d  = 9'd0;
                    end else begin
                        acc_d = acc_sum_s;
                        sat_d = sat_q | clip_s;
                        cnt_d = cnt_q + 9'd1;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result FIFO: a pop frees the head first, so push+pop on a full FIFO never drops
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        pop_s     = (fill_q != {FILL_W{1'b0}}) && out_ready;
        full_s    = (fill_q == FILL_W'(FIFO_DEPTH));
        push_ok_s = push_s && (!full_s || pop_s);
        drop_d    = push_s && full_s && !pop_s;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data_s;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= {CNT_W{1'b0}};
            sat_q    <= 1'b0;
            cnt_q    <= 9'd0;
            win_q    <= 9'd0;
            mem_q    <= '{default: {(CNT_W+1){1'b0}}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            fill_q   <= {FILL_W{1'b0}};
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            drop_q   <= drop_d;
        end
    end

    assign out_valid = (fill_q != {FILL_W{1'b0}});
    assign out_count = mem_q[rd_ptr_q][CNT_W-1:0];
    assign out_sat   = mem_q[rd_ptr_q][CNT_W];
    assign busy      = (state_q == ST_ACCUM);
    assign drop      = drop_q;

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed bench for spike_window_counter with hand-computed expectations.
module tb_spike_window_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] spikes_in;
    logic [7:0] win_len;
    logic       start;
    logic       stop;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_count;
    logic       out_sat;
    logic       busy;
    logic       drop;

    int checks   = 0;
    int failures = 0;

    spike_window_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .spikes_in (spikes_in),
        .win_len   (win_len),
        .start     (start),
        .stop      (stop),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .out_sat   (out_sat),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start(input logic [7:0] wl);
        win_len = wl;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; spikes_in = 8'h00; win_len = 8'd0;
        start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        ticks(2);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %0b exp 0", drop); end
        checks++; if ({out_sat, out_count} !== 9'h000) begin failures++; $display("FAIL reset_head: got %0h exp 0", {out_sat, out_count}); end
        rst_n = 1'b1;
        ticks(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy got %0b exp 0", busy); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1; spikes_in = 8'h03;
        do_start(8'd4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b exp 1", busy); end
        ticks(3);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early: valid got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %0b exp 1", out_valid); end
        checks++; if (out_count !== 8'd8 || out_sat !== 1'b0) begin failures++; $display("FAIL basic_result: got %0d/%0b exp 8/0", out_count, out_sat); end
        spikes_in = 8'h00;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pop: valid got %0b exp 0", out_valid); end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_stop: busy got %0b exp 0", busy); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0; spikes_in = 8'hFF;
        do_start(8'd0);
        ticks(255);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_early: valid got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_count !== 8'd255 || out_sat !== 1'b1) begin failures++; $display("FAIL sat_result: got v%0b %0d/%0b exp v1 255/1", out_valid, out_count, out_sat); end
        spikes_in = 8'h00; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        ticks(254);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_gap: valid got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_count !== 8'd0 || out_sat !== 1'b0) begin failures++; $display("FAIL sat_next: got v%0b %0d/%0b exp v1 0/0", out_valid, out_count, out_sat); end
        stop = 1'b1; out_ready = 1'b1; tick(); stop = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        out_ready = 1'b0; spikes_in = 8'h01;
        do_start(8'd2);
        ticks(2);
        checks++; if (out_valid !== 1'b1 || out_count !== 8'd2) begin failures++; $display("FAIL full_first: got v%0b %0d exp v1 2", out_valid, out_count); end
        ticks(2);
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL full_nodrop: got %0b exp 0", drop); end
        ticks(2);
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL full_drop: got %0b exp 1", drop); end
        stop = 1'b1; spikes_in = 8'h00; tick(); stop = 1'b0;
        checks++; if (drop !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL full_drop_pulse: drop %0b busy %0b exp 0 0", drop, busy); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_count !== 8'd2) begin failures++; $display("FAIL full_pop1: got v%0b %0d exp v1 2", out_valid, out_count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_pop2: valid got %0b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; spikes_in = 8'h01;
        do_start(8'd1);
        tick();
        spikes_in = 8'h03; tick();
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL b2b_head: got %0d exp 1", out_count); end
        spikes_in = 8'h07; out_ready = 1'b1; tick();
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL b2b_nodrop: got %0b exp 0", drop); end
        checks++; if (out_count !== 8'd2) begin failures++; $display("FAIL b2b_head2: got %0d exp 2", out_count); end
        stop = 1'b1; out_ready = 1'b0; tick(); stop = 1'b0;
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || out_count !== 8'd3) begin failures++; $display("FAIL b2b_tail: got v%0b %0d exp v1 3", out_valid, out_count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty: valid got %0b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_ena();
        logic [4:0] pat;
        pat = 5'b10101;
        out_ready = 1'b0; spikes_in = 8'h01;
        do_start(8'd3);
        for (int i = 0; i < 4; i++) begin
            ena = pat[i];
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ena_early: valid got %0b exp 0", out_valid); end
        ena = pat[4]; tick();
        checks++; if (out_valid !== 1'b1 || out_count !== 8'd3) begin failures++; $display("FAIL ena_result: got v%0b %0d exp v1 3", out_valid, out_count); end
        ena = 1'b0; stop = 1'b1; out_ready = 1'b1; tick();
        stop = 1'b0; out_ready = 1'b0; ena = 1'b1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ena_pop: v%0b busy %0b exp 0 0", out_valid, busy); end
    endtask

    task automatic test_stop();
        out_ready = 1'b0; spikes_in = 8'h01;
        do_start(8'd5);
        ticks(2);
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy: got %0b exp 0", busy); end
        ticks(5);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stop_nopush: valid got %0b exp 0", out_valid); end
        do_start(8'd5);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        ticks(2);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stop_restart_early: valid got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_count !== 8'd5) begin failures++; $display("FAIL stop_restart: got v%0b %0d exp v1 5", out_valid, out_count); end
        stop = 1'b1; out_ready = 1'b1; tick(); stop = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; spikes_in = 8'h01;
        do_start(8'd4);
        ticks(6);
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL arst_pre: v%0b busy %0b exp 1 1", out_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arst_async: v%0b busy %0b exp 0 0", out_valid, busy); end
        #1 rst_n = 1'b1;
        ticks(10);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arst_after: v%0b busy %0b exp 0 0", out_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_fifo_full();
        test_back_to_back();
        test_ena();
        test_stop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_window_counter.md
SPIKE_WINDOW_COUNTER -- requirements
Module: spike_window_counter

Interface
REQ-001 Parameter LANES, default 8, number of spike lanes in spikes_in.
REQ-002 Parameter CNT_W, default 8, width of the window spike count.
REQ-003 Parameter FIFO_DEPTH, default 2, result FIFO entries.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port ena  input  1  design enable; when 0, accumulation and the window counter freeze.
REQ-007 Port spikes_in  input  LANES  per-cycle spike vector from the neuron stage; bit i=1 means lane i spiked.
REQ-008 Port win_len  input  8  window length in enabled cycles; 0 means 256.
REQ-009 Port start  input  1  one-cycle pulse; begins windowing.
REQ-010 Port stop  input  1  one-cycle pulse; aborts windowing.
REQ-011 Port out_ready  input  1  consumer ready for the FIFO head.
REQ-012 Port out_valid  output  1  FIFO non-empty.
REQ-013 Port out_count  output  CNT_W  FIFO head spike count.
REQ-014 Port out_sat  output  1  FIFO head saturation flag.
REQ-015 Port busy  output  1  high in ACCUM state.
REQ-016 Port drop  output  1  one-cycle pulse when a result is discarded because the FIFO is full.

Function
REQ-017 FSM states are IDLE and ACCUM; reset state is IDLE.
REQ-018 IDLE -> ACCUM on start=1; win_len is latched that cycle; acc, sat flag and cycle counter are cleared.
REQ-019 ACCUM -> IDLE on stop=1; the partial window is discarded and nothing is pushed.
REQ-020 stop takes priority over start; start while in ACCUM is ignored.
REQ-021 In ACCUM with ena=1 and stop=0: acc <= acc + popcount(spikes_in); cycle counter increments.
REQ-022 Accumulation saturates at 2^CNT_W-1; the sat flag sets sticky for the window on any clipped add.
REQ-023 The window closes on the enabled cycle in which the cycle counter reaches latched win_len (256 for 0); that cycle's spikes are included.
REQ-024 On window close, {sat, acc_final} is pushed to the FIFO; acc, sat and counter clear; the next window starts on the following enabled cycle with no gap; the state stays ACCUM.
REQ-025 In ACCUM with ena=0: acc, sat and counter hold; the FIFO still pops.
REQ-026 out_valid rises the cycle after the push edge; out_count and out_sat show the FIFO head and are stable while out_valid=1 and out_ready=0.
REQ-027 A pop occurs on a clock edge with out_valid=1 and out_ready=1.
REQ-028 With push and pop on the same edge and the FIFO full, the pop is evaluated first and the push succeeds; no drop.
REQ-029 A push into a full FIFO without a pop discards the new result, keeps the FIFO contents, and asserts drop for exactly one cycle.
REQ-030 The FIFO is not cleared by stop or start; pending results remain poppable in IDLE.
REQ-031 busy=1 exactly when the state is ACCUM.
REQ-032 popcount counts 0..LANES; the acc adder is at least CNT_W+1 bits wide before the saturation clamp.

Reset
REQ-033 rst_n=0 asynchronously forces state IDLE; acc, counter, sat, latched win_len and FIFO pointers to 0; out_valid, out_count, out_sat, busy and drop to 0.
REQ-034 Reset asserted mid-window discards the window and all FIFO contents; after release the block stays IDLE until the next start.

Verification
REQ-035 win_len=4, start, ena=1, spikes_in=8'h03 for 4 cycles, out_ready=1 -> one result out_count=8, out_sat=0; out_valid high one cycle after the 4th accumulate edge.
REQ-036 win_len=0, spikes_in=8'hFF continuous -> after 256 cycles out_count=255, out_sat=1; next window starts with no gap.
REQ-037 win_len=2, spikes_in=8'h01, out_ready=0 for 3 windows -> 2 results of count 2 held; drop pulses once at 3rd close; then out_ready=1 -> exactly 2 pops.
REQ-038 win_len=3, ena toggled 1,0,1,0,1 with spikes_in=8'h01 -> single result count 3 after 5 cycles.
REQ-039 stop after 2 of win_len=5 cycles -> no push, busy=0 next cycle; start again -> fresh window from count 0.
REQ-040 rst_n pulsed low mid-window with 1 FIFO entry -> out_valid=0 and busy=0 immediately (asynchronously); no result ever appears for that window.
